// File: rtl/fp64_pkg.sv
// Shared binary64 definitions: converter FSM states, format widths and FPALU opcodes.
package fp64_pkg;

  localparam int EXP_BIAS = 1023;
  localparam int EXP_W    = 11;
  localparam int FRAC_W   = 52;

  localparam logic [4:0] OP_PASS_S = 5'h00;
  localparam logic [4:0] OP_PASS_T = 5'h01;
  localparam logic [4:0] OP_ADD    = 5'h02;
  localparam logic [4:0] OP_SUB    = 5'h03;
  localparam logic [4:0] OP_ZERO   = 5'h13;
  localparam logic [4:0] OP_MULT   = 5'h1E;
  localparam logic [4:0] OP_DIV    = 5'h1F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ABS,
    ST_NORM,
    ST_ROUND,
    ST_DONE
  } state_t;

endpackage

// File: rtl/lzc_64.sv
// 64-bit leading-zero counter; an all-zero input reports 64.
module lzc_64 (
  input  logic [63:0] a,
  output logic [6:0]  cnt
);

  always_comb begin
    cnt = 7'd64;
    // Ascending scan so the most significant set bit wins.
    for (int i = 0; i < 64; i++) begin
      if (a[i]) cnt = 7'(63 - i);
    end
  end

endmodule

// File: rtl/int_to_fp_64.sv
// Multi-cycle 64-bit integer to IEEE-754 binary64 converter, round-to-nearest-even.
// Define INT_TO_FP_FAST_NORM_EN for single-cycle normalization via lzc_64.
module int_to_fp_64
  import fp64_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        signed_in,
  input  logic [63:0] A,
  output logic        busy,
  output logic        done,
  output logic [63:0] Y,
  output logic        inexact
);

  localparam logic [EXP_W-1:0] EXP_INIT = EXP_W'(EXP_BIAS + 63);

  state_t             state_reg, state_next;
  logic [63:0]        a_reg, a_next;
  logic               sgn_in_reg, sgn_in_next;
  logic               sign_reg, sign_next;
  logic [63:0]        mag_reg, mag_next;
  logic [EXP_W-1:0]   exp_reg, exp_next;
  logic [63:0]        y_reg, y_next;
  logic               inexact_reg, inexact_next;

  logic               abs_sign;
  logic               guard;
  logic               sticky;
  logic               round_up;
  logic [FRAC_W:0]    frac_sum;

`ifdef INT_TO_FP_FAST_NORM_EN
  logic [6:0]         lz;

  lzc_64 u_lzc (
    .a   (mag_reg),
    .cnt (lz)
  );
`endif

  assign abs_sign = sgn_in_reg & a_reg[63];
  assign guard    = mag_reg[10];
  assign sticky   = |mag_reg[9:0];
  assign round_up = guard & (sticky | mag_reg[11]);
  assign frac_sum = {1'b0, mag_reg[62:11]} + {{FRAC_W{1'b0}}, round_up};

  always_comb begin
    state_next   = state_reg;
    a_next       = a_reg;
    sgn_in_next  = sgn_in_reg;
    sign_next    = sign_reg;
    mag_next     = mag_reg;
    exp_next     = exp_reg;
    y_next       = y_reg;
    inexact_next = inexact_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          a_next      = A;
          sgn_in_next = signed_in;
          state_next  = ST_ABS;
        end
      end
      ST_ABS: begin
        // -2^63 negates to itself, which is exactly the unsigned magnitude 2^63.
        sign_next = abs_sign;
        mag_next  = abs_sign ? -a_reg : a_reg;
        exp_next  = EXP_INIT;
        if (a_reg == 64'd0) begin
          y_next       = 64'd0;
          inexact_next = 1'b0;
          state_next   = ST_DONE;
        end else begin
          state_next = ST_NORM;
        end
      end
      ST_NORM: begin
`ifdef INT_TO_FP_FAST_NORM_EN
        mag_next   = mag_reg << lz;
        exp_next   = exp_reg - {4'b0, lz};
        state_next = ST_ROUND;
`else
        if (mag_reg[63]) begin
          state_next = ST_ROUND;
        end else begin
          mag_next = {mag_reg[62:0], 1'b0};
          exp_next = exp_reg - 11'd1;
        end
`endif
      end
      ST_ROUND: begin
        // Carry out of the fraction bumps the exponent; at most 1087, never infinity.
        if (frac_sum[FRAC_W]) begin
          y_next = {sign_reg, exp_reg + 11'd1, {FRAC_W{1'b0}}};
        end else begin
          y_next = {sign_reg, exp_reg, frac_sum[FRAC_W-1:0]};
        end
        inexact_next = guard | sticky;
        state_next   = ST_DONE;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= ST_IDLE;
      a_reg       <= 64'd0;
      sgn_in_reg  <= 1'b0;
      sign_reg    <= 1'b0;
      mag_reg     <= 64'd0;
      exp_reg     <= '0;
      y_reg       <= 64'd0;
      inexact_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      a_reg       <= a_next;
      sgn_in_reg  <= sgn_in_next;
      sign_reg    <= sign_next;
      mag_reg     <= mag_next;
      exp_reg     <= exp_next;
      y_reg       <= y_next;
      inexact_reg <= inexact_next;
    end
  end

  assign busy    = (state_reg != ST_IDLE);
  assign done    = (state_reg == ST_DONE);
  assign Y       = y_reg;
  assign inexact = inexact_reg;

endmodule

// File: tb/tb_int_to_fp_64.sv
// Directed bench for int_to_fp_64: hand-computed results, latency, busy handling and async reset.
module tb_int_to_fp_64;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        signed_in;
  logic [63:0] A;
  logic        busy;
  logic        done;
  logic [63:0] Y;
  logic        inexact;

  int checks_total  = 0;
  int checks_passed = 0;

  int_to_fp_64 dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .signed_in (signed_in),
    .A         (A),
    .busy      (busy),
    .done      (done),
    .Y         (Y),
    .inexact   (inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks_total++;
    if (observed === expected) checks_passed++;
    else $display("FAIL %s: got %h, expected %h", tag, observed, expected);
  endtask

  function automatic int exp_latency(input logic [63:0] a, input int lz);
    if (a == 64'd0) return 1;
`ifdef INT_TO_FP_FAST_NORM_EN
    return 3;
`else
    return lz + 3;
`endif
  endfunction

  // Pulse start for one cycle; returns with the time 1 unit after edge 0 (the sampling edge).
  task automatic kick(input logic s, input logic [63:0] a);
    @(negedge clk);
    start     = 1'b1;
    signed_in = s;
    A         = a;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges after the sampling edge until done; bounded by a cycle budget.
  task automatic wait_done(output int edges, output bit seen);
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 200) begin
      @(posedge clk);
      #1;
      edges++;
      if (done) seen = 1'b1;
    end
  endtask

  task automatic conv(input string tag, input logic s, input logic [63:0] a,
                      input logic [63:0] y_exp, input logic inx_exp, input int lz);
    int edges;
    bit seen;
    kick(s, a);
    check({tag, "_busy"}, 64'(busy), 64'd1);
    wait_done(edges, seen);
    check({tag, "_done"}, 64'(seen), 64'd1);
    check({tag, "_lat"}, 64'(edges), 64'(exp_latency(a, lz)));
    check({tag, "_y"}, Y, y_exp);
    check({tag, "_inx"}, 64'(inexact), 64'(inx_exp));
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, 64'(done), 64'd0);
    check({tag, "_idle"}, 64'(busy), 64'd0);
    $display("conv %-8s s=%b A=%h -> Y=%h inexact=%b latency=%0d", tag, s, a, Y, inexact, edges);
  endtask

  initial begin
    int  edges;
    int  extra;
    bit  seen;

    reset_n   = 1'b0;
    start     = 1'b0;
    signed_in = 1'b0;
    A         = 64'd0;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_y", Y, 64'd0);
    check("rst_inx", 64'(inexact), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    conv("u_one",   1'b0, 64'd1,                 64'h3FF0000000000000, 1'b0, 63);
    conv("s_m1",    1'b1, 64'hFFFFFFFFFFFFFFFF,  64'hBFF0000000000000, 1'b0, 63);
    conv("s_min",   1'b1, 64'h8000000000000000,  64'hC3E0000000000000, 1'b0, 0);
    conv("u_max",   1'b0, 64'hFFFFFFFFFFFFFFFF,  64'h43F0000000000000, 1'b1, 0);
    conv("tie_dn",  1'b0, 64'h0020000000000001,  64'h4340000000000000, 1'b1, 10);
    conv("tie_up",  1'b0, 64'h0020000000000003,  64'h4340000000000002, 1'b1, 10);
    conv("u_zero",  1'b0, 64'd0,                 64'd0,                1'b0, 64);
    conv("u_2p63",  1'b0, 64'h8000000000000000,  64'h43E0000000000000, 1'b0, 0);
    conv("s_m2",    1'b1, 64'hFFFFFFFFFFFFFFFE,  64'hC000000000000000, 1'b0, 62);
    conv("u_three", 1'b0, 64'd3,                 64'h4008000000000000, 1'b0, 62);
    conv("s_five",  1'b1, 64'd5,                 64'h4014000000000000, 1'b0, 61);

    // Start held high while busy must be ignored: one done, previous Y held meanwhile.
    kick(1'b0, 64'd1);
    @(negedge clk);
    start = 1'b1;
    A     = 64'd7;
    check("busy_yhold", Y, 64'h4014000000000000);
    repeat (2) @(negedge clk);
    start = 1'b0;
    edges = 2;
    seen  = 1'b0;
    while (!seen && edges < 200) begin
      @(posedge clk);
      #1;
      edges++;
      if (done) seen = 1'b1;
    end
    check("busy_done", 64'(seen), 64'd1);
    check("busy_lat", 64'(edges), 64'(exp_latency(64'd1, 63)));
    check("busy_y", Y, 64'h3FF0000000000000);
    extra = 0;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
    check("busy_single", 64'(extra), 64'd0);
    $display("busy-ignore: A=1 with start held, Y=%h extra_dones=%0d", Y, extra);

    // Asynchronous reset while in NORM aborts the conversion.
    kick(1'b0, 64'd1);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_y", Y, 64'd0);
    check("arst_done", 64'(done), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    extra = 0;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
    check("arst_nodone", 64'(extra), 64'd0);
    $display("reset-abort: extra_dones=%0d after release", extra);
    conv("post_rst", 1'b0, 64'd2, 64'h4000000000000000, 1'b0, 62);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
